// File: rtl/det_pkg.sv
// Shared types and term tables for the sequential determinant engine.
// Element indices address the latched 3x3 window as r*3+c.
package det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Sarrus terms: factor indices and sign (bit t set = subtract term t)
  localparam logic [3:0] T3_X [6] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0};
  localparam logic [3:0] T3_Y [6] = '{4'd4, 4'd5, 4'd3, 4'd4, 4'd3, 4'd5};
  localparam logic [3:0] T3_Z [6] = '{4'd8, 4'd6, 4'd7, 4'd6, 4'd8, 4'd7};
  localparam logic [5:0] T3_NEG   = 6'b111000;

  // 2x2 terms: +m00*m11, -m01*m10
  localparam logic [3:0] T2_X [2] = '{4'd0, 4'd1};
  localparam logic [3:0] T2_Y [2] = '{4'd4, 4'd3};
  localparam logic [1:0] T2_NEG   = 2'b10;

  function automatic int acc_w(input int data_w);
    return 3 * data_w + 3;
  endfunction

endpackage

// File: rtl/det_mul.sv
// Combinational signed multiplier, (2*DATA_W) x DATA_W -> 3*DATA_W.
// Shift-add over the bits of b; the sign bit of b carries negative weight.
module det_mul #(
  parameter int DATA_W = 8
) (
  input  logic signed [2*DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [3*DATA_W-1:0] p
);

  logic signed [3*DATA_W-1:0] a_ext;

  assign a_ext = {{DATA_W{a[2*DATA_W-1]}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (b[i]) begin
        if (i == DATA_W - 1) p = p - (a_ext <<< i);
        else                 p = p + (a_ext <<< i);
      end
    end
  end

endmodule

// File: rtl/determinant_nxn_seq.sv
// Sequential 2x2/3x3 signed determinant over the top-left corner of the matrix bus.
// One shared multiplier; 3x3 terms take two cycles (x*y, then *z).
module determinant_nxn_seq
  import det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GRID_N = 5
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                size3,
  input  logic [GRID_N*GRID_N*DATA_W-1:0]     A_flat,
  output logic                                busy,
  output logic                                done,
  output logic [DATA_W-1:0]                   det,
  output logic signed [acc_w(DATA_W)-1:0]     det_full,
  output logic                                overflow_flag,
  output logic [1:0]                          state_dbg
);

  localparam int ACC_W = acc_w(DATA_W);
  localparam int PRD_W = 3 * DATA_W;
  localparam logic signed [ACC_W-1:0] DET_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] DET_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  state_t state_q, state_d;

  logic signed [DATA_W-1:0]   m_q [9];
  logic                       size3_q;
  logic [2:0]                 term_q;
  logic                       phase_q;
  logic signed [2*DATA_W-1:0] p_q;
  logic signed [ACC_W-1:0]    acc_q;

  logic [3:0]                 x_idx, y_idx, z_idx;
  logic                       term_neg;
  logic                       term_last_cycle;
  logic                       last_term;
  logic signed [DATA_W-1:0]   x_val, y_val, z_val;
  logic signed [2*DATA_W-1:0] mul_a;
  logic signed [DATA_W-1:0]   mul_b;
  logic signed [PRD_W-1:0]    mul_p;
  logic signed [ACC_W-1:0]    prod_ext;

  // Operand selection from the current term and phase
  always_comb begin
    x_idx    = size3_q ? T3_X[term_q] : T2_X[term_q[0]];
    y_idx    = size3_q ? T3_Y[term_q] : T2_Y[term_q[0]];
    z_idx    = T3_Z[term_q];
    term_neg = size3_q ? T3_NEG[term_q] : T2_NEG[term_q[0]];
  end

  assign x_val = m_q[x_idx];
  assign y_val = m_q[y_idx];
  assign z_val = m_q[z_idx];
  assign mul_a = phase_q ? p_q : {{DATA_W{x_val[DATA_W-1]}}, x_val};
  assign mul_b = phase_q ? z_val : y_val;
  assign prod_ext = {{(ACC_W - PRD_W){mul_p[PRD_W-1]}}, mul_p};

  assign term_last_cycle = !size3_q || phase_q;
  assign last_term       = size3_q ? (term_q == 3'd5) : (term_q == 3'd1);

  det_mul #(.DATA_W(DATA_W)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (term_last_cycle && last_term) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) m_q[k] <= '0;
      size3_q       <= 1'b0;
      term_q        <= '0;
      phase_q       <= 1'b0;
      p_q           <= '0;
      acc_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      det           <= '0;
      det_full      <= '0;
      overflow_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < 9; k++)
              m_q[k] <= A_flat[((k / 3) * GRID_N + (k % 3)) * DATA_W +: DATA_W];
            size3_q <= size3;
            term_q  <= '0;
            phase_q <= 1'b0;
            acc_q   <= '0;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          if (term_last_cycle) begin
            acc_q   <= term_neg ? (acc_q - prod_ext) : (acc_q + prod_ext);
            term_q  <= term_q + 3'd1;
            phase_q <= 1'b0;
          end else begin
            // x*y of a 3x3 term always fits in 2*DATA_W
            p_q     <= mul_p[2*DATA_W-1:0];
            phase_q <= 1'b1;
          end
        end
        FIN: begin
          det_full      <= acc_q;
          det           <= acc_q[DATA_W-1:0];
          overflow_flag <= (acc_q > DET_MAX) || (acc_q < DET_MIN);
          done          <= 1'b1;
          busy          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_determinant_nxn_seq.sv
// Directed bench for determinant_nxn_seq: hand-computed determinants, latency,
// start/busy/done handshake, and reset abort.
module tb_determinant_nxn_seq;

  localparam int DATA_W = 8;
  localparam int GRID_N = 5;
  localparam int ACC_W  = 3 * DATA_W + 3;
  localparam int BUS_W  = GRID_N * GRID_N * DATA_W;

  logic                    clock;
  logic                    reset;
  logic                    start;
  logic                    size3;
  logic [BUS_W-1:0]        A_flat;
  logic                    busy;
  logic                    done;
  logic [DATA_W-1:0]       det;
  logic signed [ACC_W-1:0] det_full;
  logic                    overflow_flag;
  logic [1:0]              state_dbg;

  int checks   = 0;
  int failures = 0;

  determinant_nxn_seq #(.DATA_W(DATA_W), .GRID_N(GRID_N)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .size3         (size3),
    .A_flat        (A_flat),
    .busy          (busy),
    .done          (done),
    .det           (det),
    .det_full      (det_full),
    .overflow_flag (overflow_flag),
    .state_dbg     (state_dbg)
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Background fills the whole grid with nonzero junk so stray indexing shows up
  task automatic load_mat(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int v [9];
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    for (int i = 0; i < GRID_N * GRID_N; i++) A_flat[i*DATA_W +: DATA_W] = 8'(i * 7 + 3);
    for (int k = 0; k < 9; k++)
      A_flat[((k / 3) * GRID_N + (k % 3)) * DATA_W +: DATA_W] = 8'(v[k]);
  endtask

  // Drives one operation from the current matrix; called #1 after a posedge
  task automatic run_op(input string name, input bit s3, input int exp_lat,
                        input logic signed [ACC_W-1:0] exp_full,
                        input logic [DATA_W-1:0] exp_det, input bit exp_ovf,
                        input bit scramble);
    int lat;
    int busy_cnt;
    start = 1'b1;
    size3 = s3;
    @(posedge clock); #1;
    start = 1'b0;
    if (scramble) begin
      load_mat(1, 0, 0, 0, 1, 0, 0, 0, 1);
      size3 = ~s3;
    end
    lat = 0;
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy) busy_cnt++;
      @(posedge clock); #1;
      lat++;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d cycles", name, lat);
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_cnt !== exp_lat) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat);
    end
    checks++;
    if (det_full !== exp_full) begin
      failures++;
      $display("FAIL %s det_full: got %0d expected %0d", name, det_full, exp_full);
    end
    checks++;
    if (det !== exp_det) begin
      failures++;
      $display("FAIL %s det: got %h expected %h", name, det, exp_det);
    end
    checks++;
    if (overflow_flag !== exp_ovf) begin
      failures++;
      $display("FAIL %s overflow: got %b expected %b", name, overflow_flag, exp_ovf);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: got %b expected 0", name, done);
    end
    checks++;
    if (det_full !== exp_full) begin
      failures++;
      $display("FAIL %s hold: got %0d expected %0d", name, det_full, exp_full);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    size3 = 1'b0;
    load_mat(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, det, det_full, overflow_flag, state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b det=%h det_full=%0d ovf=%b state=%0d expected all 0",
               busy, done, det, det_full, overflow_flag, state_dbg);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_2x2();
    load_mat(3, 2, 9, 1, 4, 9, 9, 9, 9);
    run_op("det2_basic", 1'b0, 3, 10, 8'd10, 1'b0, 1'b0);
    load_mat(127, 0, 9, 0, 127, 9, 9, 9, 9);
    run_op("det2_ovf", 1'b0, 3, 16129, 8'h01, 1'b1, 1'b0);
    load_mat(-128, 0, 9, 0, 1, 9, 9, 9, 9);
    run_op("det2_min", 1'b0, 3, -128, 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_3x3();
    load_mat(2, -3, 1, 2, 0, -1, 1, 4, 5);
    run_op("det3_basic", 1'b1, 13, 49, 8'd49, 1'b0, 1'b0);
    load_mat(-128, 0, 0, 0, -128, 0, 0, 0, -128);
    run_op("det3_diag", 1'b1, 13, -2097152, 8'h00, 1'b1, 1'b0);
    load_mat(1, 0, 0, 0, 1, 0, 0, 0, 1);
    run_op("det3_ident", 1'b1, 13, 1, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_mid_op_change();
    load_mat(2, -3, 1, 2, 0, -1, 1, 4, 5);
    run_op("mid_op_change", 1'b1, 13, 49, 8'd49, 1'b0, 1'b1);
  endtask

  // Start held high: accept, 2 CALC, FIN, re-accept -> one done per 4 cycles
  task automatic test_back_to_back();
    int done_cnt;
    load_mat(5, 1, 9, 2, 3, 9, 9, 9, 9);
    size3 = 1'b0;
    start = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 5) begin
      failures++;
      $display("FAIL back_to_back_count: got %0d expected 5", done_cnt);
    end
    checks++;
    if (det_full !== 13) begin
      failures++;
      $display("FAIL back_to_back_value: got %0d expected 13", det_full);
    end
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    load_mat(2, -3, 1, 2, 0, -1, 1, 4, 5);
    size3 = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, det, det_full, overflow_flag, state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_abort_outputs: busy=%b done=%b det=%h det_full=%0d ovf=%b state=%0d expected all 0",
               busy, done, det, det_full, overflow_flag, state_dbg);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL reset_abort_no_done: got %0d pulses expected 0", done_cnt);
    end
    load_mat(4, 7, 0, 2, 6, 0, 0, 0, 3);
    run_op("after_reset", 1'b1, 13, 30, 8'd30, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_2x2();
    test_3x3();
    test_mid_op_change();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
